// File: rtl/spi_frame_receiver.sv
// SPI slave frame receiver: address, R/W bit, then write data in or read data out.
// Define SPI_FRAME_ERR_EN to add the frame_err output (pulses on a frame aborted by chip-select).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no frame; waits for cs_cond low (and for a high cs after reset)
// GET_ADDR | shifting ADDR_W address bits in on sclk_pos, MSB first
// GET_RW   | sampling the R/W bit on the next sclk_pos
// WRITE    | shifting DATA_W data bits in, then one-cycle mem_we
// RD_REQ   | one-cycle rd_req to the memory
// RD_LOAD  | capturing rd_data into the TX shift register
// READ     | driving TX MSB on miso, shifting on each sclk_neg
// DONE     | frame complete; SCLK ignored until cs_cond rises
module spi_frame_receiver #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_cond,
  input  logic              mosi_cond,
  input  logic              sclk_pos,
  input  logic              sclk_neg,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              mem_we,
  output logic              rd_req,
  output logic              miso,
  output logic              miso_oe
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_RW,
    WRITE,
    RD_REQ,
    RD_LOAD,
    READ,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] tx;
  logic             armed;
  logic             pos_ev, neg_ev;
  logic             addr_shift, data_shift, tx_shift, cnt_inc;

  // A coincident falling-edge pulse is dropped in favour of the rising edge.
  assign pos_ev = sclk_pos;
  assign neg_ev = sclk_neg & ~sclk_pos;

  assign addr_shift = (state == GET_ADDR) && pos_ev && !cs_cond;
  assign data_shift = (state == WRITE) && pos_ev && !cs_cond && (cnt < CNT_W'(DATA_W));
  assign tx_shift   = (state == READ) && neg_ev && !cs_cond;
  assign cnt_inc    = addr_shift | data_shift | tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    rd_req   = 1'b0;
    if (state != IDLE && cs_cond) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:     if (!cs_cond && armed) state_nx = GET_ADDR;
        GET_ADDR: if (pos_ev && cnt == CNT_W'(ADDR_W - 1)) state_nx = GET_RW;
        GET_RW:   if (pos_ev) state_nx = mosi_cond ? RD_REQ : WRITE;
        WRITE: begin
          if (cnt == CNT_W'(DATA_W)) begin
            mem_we   = 1'b1;
            state_nx = DONE;
          end
        end
        RD_REQ: begin
          rd_req   = 1'b1;
          state_nx = RD_LOAD;
        end
        RD_LOAD:  state_nx = READ;
        READ:     if (neg_ev && cnt == CNT_W'(DATA_W - 1)) state_nx = DONE;
        DONE:     state_nx = DONE;
      endcase
    end
  end

  // armed blocks a frame that was already in progress when reset released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      addr    <= '0;
      wr_data <= '0;
      tx      <= '0;
      armed   <= 1'b0;
    end else begin
      if (cs_cond) armed <= 1'b1;
      if (state_nx != state) cnt <= '0;
      else if (cnt_inc)      cnt <= cnt + 1'b1;
      if (addr_shift) addr <= {addr[ADDR_W-2:0], mosi_cond};
      if (data_shift) wr_data <= {wr_data[DATA_W-2:0], mosi_cond};
      if (state == RD_LOAD) tx <= rd_data;
      else if (tx_shift)    tx <= {tx[DATA_W-2:0], 1'b0};
    end
  end

  assign miso    = (state == READ) ? tx[DATA_W-1] : 1'b0;
  assign miso_oe = (state == READ);

`ifdef SPI_FRAME_ERR_EN
  assign frame_err = cs_cond && (state != IDLE) && (state != DONE);
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench for spi_frame_receiver: directed and random frames against a
// frame-level memory model; define SPI_FRAME_ERR_EN to also check frame_err.
module tb_spi_frame_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_cond = 1'b1;
  logic       mosi_cond = 1'b0;
  logic       sclk_pos = 1'b0;
  logic       sclk_neg = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic [6:0] addr;
  logic [7:0] wr_data;
  logic       mem_we, rd_req, miso, miso_oe;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  int exp_err = 0;
  logic [6:0] we_addr = '0;
  logic [7:0] we_data = '0;

  logic [7:0] tb_mem [128];
  logic       tb_vld [128] = '{default: 1'b0};
  logic [7:0] model_mem [128];

  spi_frame_receiver #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cs_cond(cs_cond), .mosi_cond(mosi_cond),
    .sclk_pos(sclk_pos), .sclk_neg(sclk_neg), .rd_data(rd_data),
    .addr(addr), .wr_data(wr_data), .mem_we(mem_we), .rd_req(rd_req),
    .miso(miso), .miso_oe(miso_oe)
`ifdef SPI_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [6:0] a);
    if (a == 7'h2A) return 8'h3C;
    return 8'(a) * 8'd37 + 8'd11;
  endfunction

  // Memory device seen by the DUT, plus strobe monitors.
  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt       <= we_cnt + 1;
      we_addr      <= addr;
      we_data      <= wr_data;
      tb_mem[addr] <= wr_data;
      tb_vld[addr] <= 1'b1;
    end
    if (rd_req) begin
      rd_cnt  <= rd_cnt + 1;
      rd_data <= tb_vld[addr] ? tb_mem[addr] : init_val(addr);
    end
`ifdef SPI_FRAME_ERR_EN
    if (frame_err) err_cnt <= err_cnt + 1;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic spi_bit(input logic b, input logic both, output logic m, output logic oe);
    @(negedge clk);
    mosi_cond = b; sclk_pos = 1'b1; sclk_neg = both;
    @(negedge clk);
    sclk_pos = 1'b0; sclk_neg = 1'b0;
    m = miso; oe = miso_oe;
    if (!both) begin
      @(negedge clk);
      m = miso; oe = miso_oe;
      sclk_neg = 1'b1;
      @(negedge clk);
      sclk_neg = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk); cs_cond = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk); cs_cond = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_header(input logic [6:0] a, input logic rw, input int coin_idx);
    logic m, oe;
    for (int i = 6; i >= 0; i--) spi_bit(a[i], (i == coin_idx), m, oe);
    spi_bit(rw, 1'b0, m, oe);
  endtask

  task automatic send_data(input logic [7:0] d, input int nbits);
    logic m, oe;
    for (int i = 0; i < nbits; i++) spi_bit(d[7-i], 1'b0, m, oe);
  endtask

  task automatic recv_data(input int nbits, output logic [7:0] bits, output logic oe_all);
    logic m, oe;
    bits = 8'h00; oe_all = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(1'($urandom_range(0, 1)), 1'b0, m, oe);
      bits[7-i] = m;
      oe_all &= oe;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({addr, wr_data, mem_we, rd_req, miso, miso_oe} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h wr_data=%h we=%b rd=%b miso=%b oe=%b, want all 0",
               addr, wr_data, mem_we, rd_req, miso, miso_oe);
    end
`ifdef SPI_FRAME_ERR_EN
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_we, rd_req, miso_oe} !== 3'b000) begin
      n_fail++; $display("FAIL post_reset_strobes: got %b want 000", {mem_we, rd_req, miso_oe});
    end
  endtask

  task automatic test_write(input logic [6:0] a, input logic [7:0] d, input int coin_idx);
    int w0 = we_cnt;
    cs_low();
    send_header(a, 1'b0, coin_idx);
    send_data(d, 8);
    cs_high();
    model_mem[a] = d;
    n_checks++;
    if (we_cnt - w0 !== 1) begin
      n_fail++; $display("FAIL write_we_cycles a=%h: got %0d want 1", a, we_cnt - w0);
    end
    n_checks++;
    if ({we_addr, we_data} !== {a, d}) begin
      n_fail++; $display("FAIL write_strobe_data: got %h/%h want %h/%h", we_addr, we_data, a, d);
    end
    n_checks++;
    if ({addr, wr_data} !== {a, d}) begin
      n_fail++; $display("FAIL write_held: got addr=%h wr_data=%h want %h/%h", addr, wr_data, a, d);
    end
  endtask

  task automatic test_read(input logic [6:0] a);
    int r0 = rd_cnt;
    logic [7:0] bits;
    logic oe_all;
    cs_low();
    send_header(a, 1'b1, -1);
    recv_data(8, bits, oe_all);
    cs_high();
    n_checks++;
    if (rd_cnt - r0 !== 1) begin
      n_fail++; $display("FAIL read_req_cycles a=%h: got %0d want 1", a, rd_cnt - r0);
    end
    n_checks++;
    if (bits !== model_mem[a]) begin
      n_fail++; $display("FAIL read_miso_bits a=%h: got %h want %h", a, bits, model_mem[a]);
    end
    n_checks++;
    if (oe_all !== 1'b1 || miso_oe !== 1'b0 || miso !== 1'b0) begin
      n_fail++; $display("FAIL read_oe a=%h: got during=%b after=%b miso=%b want 1/0/0",
                         a, oe_all, miso_oe, miso);
    end
  endtask

  task automatic test_abort();
    int w0 = we_cnt;
    cs_low();
    send_header(7'h21, 1'b0, -1);
    send_data(8'hC3, 4);
    cs_high();
    exp_err++;
    n_checks++;
    if (we_cnt !== w0) begin
      n_fail++; $display("FAIL abort_no_we: got %0d strobes want 0", we_cnt - w0);
    end
`ifdef SPI_FRAME_ERR_EN
    n_checks++;
    if (err_cnt !== exp_err) begin
      n_fail++; $display("FAIL abort_frame_err: got %0d pulses want %0d", err_cnt, exp_err);
    end
`endif
    // Frame straight after the abort proves the DUT returned to IDLE.
    test_write(7'h22, 8'h96, -1);
  endtask

  task automatic test_abort_last_bit();
    int w0 = we_cnt;
    logic [7:0] d = 8'h5B;
    cs_low();
    send_header(7'h31, 1'b0, -1);
    send_data(d, 7);
    @(negedge clk); mosi_cond = d[0]; sclk_pos = 1'b1; cs_cond = 1'b1;
    @(negedge clk); sclk_pos = 1'b0;
    @(negedge clk); sclk_neg = 1'b1;
    @(negedge clk); sclk_neg = 1'b0;
    @(negedge clk);
    exp_err++;
    n_checks++;
    if (we_cnt !== w0) begin
      n_fail++; $display("FAIL abort_last_bit_we: got %0d strobes want 0", we_cnt - w0);
    end
`ifdef SPI_FRAME_ERR_EN
    n_checks++;
    if (err_cnt !== exp_err) begin
      n_fail++; $display("FAIL abort_last_bit_err: got %0d pulses want %0d", err_cnt, exp_err);
    end
`endif
  endtask

  task automatic test_done_extra();
    int w1, r1;
    logic m, oe;
    cs_low();
    send_header(7'h45, 1'b0, -1);
    send_data(8'hE7, 8);
    model_mem[7'h45] = 8'hE7;
    w1 = we_cnt; r1 = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      spi_bit(1'($urandom_range(0, 1)), 1'b0, m, oe);
      n_checks++;
      if (oe !== 1'b0 || m !== 1'b0) begin
        n_fail++; $display("FAIL done_extra_miso[%0d]: got oe=%b miso=%b want 0/0", i, oe, m);
      end
    end
    n_checks++;
    if (we_cnt !== w1 || rd_cnt !== r1 || addr !== 7'h45 || wr_data !== 8'hE7) begin
      n_fail++; $display("FAIL done_extra_stable: got we+%0d rd+%0d addr=%h data=%h want 0/0/45/e7",
                         we_cnt - w1, rd_cnt - r1, addr, wr_data);
    end
    cs_high();
  endtask

  task automatic test_reset_in_read();
    logic [7:0] bits;
    logic oe_all;
    int r0, w0;
    cs_low();
    send_header(7'h2A, 1'b1, -1);
    recv_data(3, bits, oe_all);
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_checks++;
    if ({miso_oe, miso, rd_req, mem_we} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_in_read: got oe=%b miso=%b rd=%b we=%b want 0000",
                         miso_oe, miso, rd_req, mem_we);
    end
    @(negedge clk); rst_n = 1'b1;
    r0 = rd_cnt; w0 = we_cnt;
    // Chip select still low from the interrupted frame: must be ignored.
    send_header(7'h33, 1'b1, -1);
    recv_data(8, bits, oe_all);
    send_header(7'h33, 1'b0, -1);
    send_data(8'h77, 8);
    n_checks++;
    if (rd_cnt !== r0 || we_cnt !== w0) begin
      n_fail++; $display("FAIL reset_wait_cs: got rd+%0d we+%0d want 0/0", rd_cnt - r0, we_cnt - w0);
    end
    cs_high();
    test_write(7'h33, 8'h77, -1);
    test_read(7'h33);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [6:0] a = 7'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) test_write(a, 8'($urandom), -1);
      else                           test_read(a);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) model_mem[i] = init_val(7'(i));
    test_reset();
    test_write(7'h15, 8'hA5, -1);
    test_read(7'h2A);
    test_write(7'h4B, 8'h5A, 3);
    test_write(7'h0C, 8'h3E, 0);
    test_abort();
    test_abort_last_bit();
    test_done_extra();
    test_reset_in_read();
    test_random();
`ifdef SPI_FRAME_ERR_EN
    n_checks++;
    if (err_cnt !== exp_err) begin
      n_fail++; $display("FAIL frame_err_total: got %0d want %0d", err_cnt, exp_err);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
